dispatch_rr: RTL and testbench
==============================

// Module: dispatch_rr
// PURPOSE
//  Parametrised dispatch stage between rename and the reservation stations (RS).
//  - Buffers renamed ops per functional-unit channel in a small FIFO.
//  - Picks at most one op per cycle by round-robin, not fixed priority.
//  - For the picked op: allocates ROB/LSQ, resolves source readiness
//    (PRF + NUM_CDB-wide CDB forwarding), writes exactly one RS.
// PARAMETERS
//  NUM_CH   3  number of FU channels/RSs (ch0 ALU, ch1 branch, ch2 LSU by convention)
//  DEPTH    2  entries per channel FIFO (>=1)
//  NUM_CDB  3  number of CDB wakeup broadcast ports
//  PREG_W   7  physical register index width
//  ROB_W    5  ROB tag width
// PORTS
//  clk              in   1                 clock
//  reset            in   1                 async, active-low; asserts all state to reset values
//  valid_in         in   1                 rename has an op
//  data_in          in   rename_data       renamed op
//  fu_sel_in        in   NUM_CH            one-hot target channel of data_in
//  ready_in         out  1                 dispatch accepts data_in
//  nr_valid_out     out  1                 mark nr_reg_out busy in PRF
//  nr_reg_out       out  PREG_W            data_in.pd_new
//  query_ps1/ps2    out  PREG_W            PRF readiness query, granted op's sources
//  pr1/pr2_is_ready in   1                 PRF answer for query_ps1/ps2
//  cdb_valid        in   NUM_CDB           CDB broadcast valids
//  cdb_preg         in   NUM_CDB*PREG_W    CDB broadcast tags, port k at [k*PREG_W +: PREG_W]
//  rob_full_in      in   1                 ROB cannot allocate
//  rob_tag_in       in   ROB_W             tag the ROB assigns to this cycle's allocation
//  rob_we_out       out  1                 ROB allocate
//  rob_pd_new_out   out  PREG_W            granted op's pd_new
//  rob_pd_old_out   out  PREG_W            granted op's pd_old
//  rob_pc_out       out  32                granted op's pc
//  rs_space_in      in   NUM_CH            per-RS free-slot flag
//  rs_we_out        out  NUM_CH            one-hot RS write, same cycle as rob_we_out
//  rs_pkt_out       out  dispatch_pipeline_data  packet shared by all RSs
//  lsq_alloc_valid_out out 1               LSQ allocate for a granted load/store
//  lsq_rob_tag_out  out  ROB_W             rob_tag_in when lsq_alloc_valid_out, else 0
//  mispredict       in   1                 flush
// BEHAVIOUR
//  - Reset: all FIFOs empty, rr_ptr=0. With FIFOs empty, every output is 0
//    except ready_in=1 (mispredict low).
//  - Accept: acc = valid_in && ready_in.
//    ready_in = !mispredict && count[c]<DEPTH, where c = channel of fu_sel_in.
//    No pop-through: a full FIFO stalls even if it pops in the same cycle.
//  - nr_valid_out = acc && pd_new!=0 (combinational, input side).
//    acc pushes data_in into FIFO c.
//  - Latency: an op can be granted no earlier than the cycle after it is accepted.
//    There is no input bypass.
//  - Eligible[c] = FIFO c non-empty && rs_space_in[c] && !rob_full_in && !mispredict.
//  - Grant g = first eligible channel scanning rr_ptr, rr_ptr+1, ... mod NUM_CH.
//    On a grant: pop FIFO g, rob_we_out=1, rs_we_out=1<<g, rr_ptr <= (g+1) mod NUM_CH.
//    With no grant, rr_ptr holds.
//  - Idle outputs: with no grant, rob_we_out, rs_we_out and the lsq outputs are 0.
//    query_*, rob_pd_*, rob_pc_out and rs_pkt_out show the head of the first
//    non-empty FIFO in rr order, else 0.
//  - rs_pkt_out fields:
//    Opcode/pc/func3/func7/imm[31:0] from the op; prd=pd_new, pr1=ps1, pr2=ps2,
//    rob_index=rob_tag_in.
//    pr1_ready = (ps1==0) || pr1_is_ready || any k: cdb_valid[k] && cdb_preg[k]==ps1.
//    pr2_ready is the same, using ps2.
//  - lsq_alloc_valid_out = rob_we_out && Opcode in {0000011, 0100011}.
//  - Simultaneous push and pop on one channel: count unchanged, pointers both advance.
//    Push on one channel and pop on another are independent.
//  - mispredict: all FIFOs cleared at the next edge. In that cycle ready_in=0,
//    rob_we_out=0, rs_we_out=0, nr_valid_out=0. rr_ptr is kept.
//    Buffered ops hold no ROB tag, so all are younger than the branch and are discarded.
//  - Reset mid-operation: state clears immediately (async); in-flight buffered ops are lost.
//  - Pointer wrap at DEPTH uses mod-DEPTH increment, so DEPTH need not be a power of 2.
//    count is $clog2(DEPTH+1) bits wide.
// STRUCTURE
//  - types_pkg (shared) gains: OPC_LOAD, OPC_STORE constants.
//    rename_data and dispatch_pipeline_data already live there.
//  - Sub-module dispatch_fifo #(T,DEPTH): flushable FIFO exposing push/pop/head/count.
//    Instanced NUM_CH times via generate.
//  - RR arbiter, readiness and CDB compare stay inline (loops over NUM_CH/NUM_CDB).
// TESTING
//  1. Reset low 3 cycles then high -> ready_in=1, rob_we_out=0, rs_we_out=0.
//     ALU op pd_new=9 accepted -> nr_valid_out=1 same cycle; next cycle rs_we_out=001, rob_pd_new_out=9.
//  2. Two ALU ops then a third with DEPTH=2, rs_space_in[0]=0 -> third sees ready_in=0.
//     rs_space_in[0]=1 -> one grant/cycle; ready_in=1 the cycle after the first pop.
//  3. All 3 FIFOs non-empty, all spaces 1 -> grants 001,010,100,001 in successive cycles
//     (starting rr_ptr=0).
//  4. Granted op ps1=12, PRF not ready, cdb_valid=010, cdb_preg port1=12 -> pr1_ready=1.
//     Op with ps2=0 -> pr2_ready=1.
//  5. Store (0100011) granted with rob_tag_in=17 -> lsq_alloc_valid_out=1, lsq_rob_tag_out=17.
//     ALU grant -> both outputs 0.
//  6. Ops buffered in two channels, mispredict=1 for one cycle -> that cycle no writes.
//     Next cycle all FIFOs empty, rr_ptr unchanged. rob_full_in=1 -> no grant, FIFOs hold.

Source files
------------

// File: rtl/dispatch_rr_pkg.sv
// Shared types for the dispatch stage: renamed-op and RS-packet layouts plus memory opcodes.
package dispatch_rr_pkg;

    localparam int PREG_WIDTH = 7;
    localparam int ROB_WIDTH  = 5;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef struct packed {
        logic [31:0]           pc;
        logic [6:0]            opcode;
        logic [2:0]            func3;
        logic [6:0]            func7;
        logic [31:0]           imm;
        logic [PREG_WIDTH-1:0] ps1;
        logic [PREG_WIDTH-1:0] ps2;
        logic [PREG_WIDTH-1:0] pd_new;
        logic [PREG_WIDTH-1:0] pd_old;
    } rename_data;

    typedef struct packed {
        logic [6:0]            opcode;
        logic [31:0]           pc;
        logic [2:0]            func3;
        logic [6:0]            func7;
        logic [31:0]           imm;
        logic [PREG_WIDTH-1:0] prd;
        logic [PREG_WIDTH-1:0] pr1;
        logic [PREG_WIDTH-1:0] pr2;
        logic                  pr1_ready;
        logic                  pr2_ready;
        logic [ROB_WIDTH-1:0]  rob_index;
    } dispatch_pipeline_data;

    function automatic logic is_mem_op(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/dispatch_rr_if.sv
// Rename-to-dispatch handshake: renamed op with its target channel, and the PRF busy-mark.
interface dispatch_rr_if #(
    parameter int NUM_CH = 3
);
    import dispatch_rr_pkg::*;

    logic                  valid_in;
    rename_data            data_in;
    logic [NUM_CH-1:0]     fu_sel_in;
    logic                  ready_in;
    logic                  nr_valid_out;
    logic [PREG_WIDTH-1:0] nr_reg_out;

    modport master (
        output valid_in, data_in, fu_sel_in,
        input  ready_in, nr_valid_out, nr_reg_out
    );

    modport slave (
        input  valid_in, data_in, fu_sel_in,
        output ready_in, nr_valid_out, nr_reg_out
    );

endinterface

// File: rtl/dispatch_fifo.sv
// Small flushable FIFO holding renamed ops for one functional-unit channel.
module dispatch_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 2,
    parameter int  CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  T                 push_data,
    output T                 head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/dispatch_rr.sv
// Dispatch stage: per-channel op buffers, round-robin pick of one op per cycle,
// ROB/LSQ allocation, source readiness via PRF plus CDB forwarding, single RS write.
module dispatch_rr
    import dispatch_rr_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int DEPTH   = 2,
    parameter int NUM_CDB = 3,
    parameter int PREG_W  = PREG_WIDTH,
    parameter int ROB_W   = ROB_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    dispatch_rr_if.slave              ren,
    output logic [PREG_W-1:0]         query_ps1,
    output logic [PREG_W-1:0]         query_ps2,
    input  logic                      pr1_is_ready,
    input  logic                      pr2_is_ready,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*PREG_W-1:0] cdb_preg,
    input  logic                      rob_full_in,
    input  logic [ROB_W-1:0]          rob_tag_in,
    output logic                      rob_we_out,
    output logic [PREG_W-1:0]         rob_pd_new_out,
    output logic [PREG_W-1:0]         rob_pd_old_out,
    output logic [31:0]               rob_pc_out,
    input  logic [NUM_CH-1:0]         rs_space_in,
    output logic [NUM_CH-1:0]         rs_we_out,
    output dispatch_pipeline_data     rs_pkt_out,
    output logic                      lsq_alloc_valid_out,
    output logic [ROB_W-1:0]          lsq_rob_tag_out,
    input  logic                      mispredict
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int RR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [RR_W-1:0]   rr_ptr;
    rename_data        head  [NUM_CH];
    logic [CNT_W-1:0]  count [NUM_CH];
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] non_empty;
    logic [NUM_CH-1:0] eligible;
    logic [RR_W-1:0]   in_ch;
    logic              acc;
    logic              grant_vld;
    logic [RR_W-1:0]   grant_ch;
    logic              show_vld;
    logic [RR_W-1:0]   show_ch;
    rename_data        shown;
    logic              pr1_rdy;
    logic              pr2_rdy;

    function automatic int rr_idx(input int base, input int off);
        return (base + off) % NUM_CH;
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        dispatch_fifo #(
            .T     (rename_data),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .flush     (mispredict),
            .push      (push[c]),
            .pop       (pop[c]),
            .push_data (ren.data_in),
            .head      (head[c]),
            .count     (count[c])
        );
    end

    // Input side: no pop-through, so a full channel stalls rename even while it drains.
    always_comb begin
        in_ch = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (ren.fu_sel_in[c]) in_ch = RR_W'(c);
        end
        ren.ready_in     = !mispredict && (int'(count[in_ch]) < DEPTH);
        acc              = ren.valid_in && ren.ready_in;
        ren.nr_valid_out = acc && (ren.data_in.pd_new != '0);
        ren.nr_reg_out   = acc ? ren.data_in.pd_new : '0;
        push             = acc ? (NUM_CH'(1) << in_ch) : '0;
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        show_vld  = 1'b0;
        show_ch   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            non_empty[c] = (count[c] != '0);
            eligible[c]  = non_empty[c] && rs_space_in[c] && !rob_full_in && !mispredict;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!grant_vld && eligible[rr_idx(int'(rr_ptr), i)]) begin
                grant_vld = 1'b1;
                grant_ch  = RR_W'(rr_idx(int'(rr_ptr), i));
            end
            if (!show_vld && non_empty[rr_idx(int'(rr_ptr), i)]) begin
                show_vld = 1'b1;
                show_ch  = RR_W'(rr_idx(int'(rr_ptr), i));
            end
        end
        pop = grant_vld ? (NUM_CH'(1) << grant_ch) : '0;
    end

    // When idle, the outputs preview the op that would be picked next.
    always_comb begin
        shown = '0;
        if (grant_vld)     shown = head[grant_ch];
        else if (show_vld) shown = head[show_ch];

        pr1_rdy = (shown.ps1 == '0) || pr1_is_ready;
        pr2_rdy = (shown.ps2 == '0) || pr2_is_ready;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (cdb_valid[k] && (cdb_preg[k*PREG_W +: PREG_W] == shown.ps1)) pr1_rdy = 1'b1;
            if (cdb_valid[k] && (cdb_preg[k*PREG_W +: PREG_W] == shown.ps2)) pr2_rdy = 1'b1;
        end

        query_ps1      = shown.ps1;
        query_ps2      = shown.ps2;
        rob_pd_new_out = shown.pd_new;
        rob_pd_old_out = shown.pd_old;
        rob_pc_out     = shown.pc;
        rob_we_out     = grant_vld;
        rs_we_out      = pop;

        rs_pkt_out = '0;
        if (show_vld) begin
            rs_pkt_out.opcode    = shown.opcode;
            rs_pkt_out.pc        = shown.pc;
            rs_pkt_out.func3     = shown.func3;
            rs_pkt_out.func7     = shown.func7;
            rs_pkt_out.imm       = shown.imm;
            rs_pkt_out.prd       = shown.pd_new;
            rs_pkt_out.pr1       = shown.ps1;
            rs_pkt_out.pr2       = shown.ps2;
            rs_pkt_out.pr1_ready = pr1_rdy;
            rs_pkt_out.pr2_ready = pr2_rdy;
            rs_pkt_out.rob_index = rob_tag_in;
        end

        lsq_alloc_valid_out = grant_vld && is_mem_op(shown.opcode);
        lsq_rob_tag_out     = lsq_alloc_valid_out ? rob_tag_in : '0;
    end

    // Round-robin pointer survives a flush; only reset returns it to channel 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (grant_vld) begin
            rr_ptr <= (int'(grant_ch) == NUM_CH - 1) ? '0 : grant_ch + 1'b1;
        end
    end

endmodule

// File: tb/tb_dispatch_rr.sv
// Bench for dispatch_rr: queue-based reference model checked every cycle, plus directed literal checks.
module tb_dispatch_rr;
    import dispatch_rr_pkg::*;

    localparam int NCH   = 3;
    localparam int DEPTH = 2;
    localparam int NCDB  = 3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [6:0]             query_ps1, query_ps2;
    logic                   pr1_is_ready, pr2_is_ready;
    logic [NCDB-1:0]        cdb_valid;
    logic [NCDB*7-1:0]      cdb_preg;
    logic                   rob_full_in;
    logic [4:0]             rob_tag_in;
    logic                   rob_we_out;
    logic [6:0]             rob_pd_new_out, rob_pd_old_out;
    logic [31:0]            rob_pc_out;
    logic [NCH-1:0]         rs_space_in;
    logic [NCH-1:0]         rs_we_out;
    dispatch_pipeline_data  rs_pkt_out;
    logic                   lsq_alloc_valid_out;
    logic [4:0]             lsq_rob_tag_out;
    logic                   mispredict;

    int n_chk  = 0;
    int n_fail = 0;

    dispatch_rr_if #(.NUM_CH(NCH)) rif ();

    dispatch_rr #(.NUM_CH(NCH), .DEPTH(DEPTH), .NUM_CDB(NCDB), .PREG_W(7), .ROB_W(5)) dut (
        .clk                 (clk),
        .reset               (reset),
        .ren                 (rif),
        .query_ps1           (query_ps1),
        .query_ps2           (query_ps2),
        .pr1_is_ready        (pr1_is_ready),
        .pr2_is_ready        (pr2_is_ready),
        .cdb_valid           (cdb_valid),
        .cdb_preg            (cdb_preg),
        .rob_full_in         (rob_full_in),
        .rob_tag_in          (rob_tag_in),
        .rob_we_out          (rob_we_out),
        .rob_pd_new_out      (rob_pd_new_out),
        .rob_pd_old_out      (rob_pd_old_out),
        .rob_pc_out          (rob_pc_out),
        .rs_space_in         (rs_space_in),
        .rs_we_out           (rs_we_out),
        .rs_pkt_out          (rs_pkt_out),
        .lsq_alloc_valid_out (lsq_alloc_valid_out),
        .lsq_rob_tag_out     (lsq_rob_tag_out),
        .mispredict          (mispredict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic rename_data mk(input logic [31:0] pc, input logic [6:0] opc,
                                      input logic [6:0] ps1, input logic [6:0] ps2,
                                      input logic [6:0] pdn, input logic [6:0] pdo);
        rename_data d;
        d.pc     = pc;
        d.opcode = opc;
        d.func3  = pc[4:2];
        d.func7  = pc[10:4];
        d.imm    = pc ^ 32'hA5A5_0000;
        d.ps1    = ps1;
        d.ps2    = ps2;
        d.pd_new = pdn;
        d.pd_old = pdo;
        return d;
    endfunction

    // Reference model: one queue per channel and a round-robin start channel.
    rename_data q [NCH][$];
    int         rr = 0;
    logic       p_acc;
    int         p_ch;
    int         p_g;
    rename_data p_data;
    logic       p_flush;

    function automatic logic src_ready(input logic [6:0] ps, input logic prf);
        if (ps == 7'd0 || prf) return 1'b1;
        for (int k = 0; k < NCDB; k++) begin
            if (cdb_valid[k] && cdb_preg[k*7 +: 7] == ps) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_eval();
        int s;
        int g;
        int c;
        logic e_ready;
        logic e_mem;
        rename_data sh;
        dispatch_pipeline_data pk;
        if (!reset) begin
            for (int i = 0; i < NCH; i++) q[i].delete();
            rr = 0;
        end
        p_ch = 0;
        for (int i = NCH - 1; i >= 0; i--) if (rif.fu_sel_in[i]) p_ch = i;
        e_ready = !mispredict && (q[p_ch].size() < DEPTH);
        p_acc   = rif.valid_in && e_ready;
        s = -1;
        g = -1;
        for (int i = 0; i < NCH; i++) begin
            c = (rr + i) % NCH;
            if (s < 0 && q[c].size() > 0) s = c;
            if (g < 0 && q[c].size() > 0 && rs_space_in[c] && !rob_full_in && !mispredict) g = c;
        end
        sh = '0;
        if (g >= 0)      sh = q[g][0];
        else if (s >= 0) sh = q[s][0];
        pk = '0;
        if (s >= 0) begin
            pk.opcode    = sh.opcode;
            pk.pc        = sh.pc;
            pk.func3     = sh.func3;
            pk.func7     = sh.func7;
            pk.imm       = sh.imm;
            pk.prd       = sh.pd_new;
            pk.pr1       = sh.ps1;
            pk.pr2       = sh.ps2;
            pk.pr1_ready = src_ready(sh.ps1, pr1_is_ready);
            pk.pr2_ready = src_ready(sh.ps2, pr2_is_ready);
            pk.rob_index = rob_tag_in;
        end
        e_mem = (g >= 0) && (sh.opcode == 7'h03 || sh.opcode == 7'h23);
        chk("m_ready_in", 128'(rif.ready_in), 128'(e_ready));
        chk("m_nr_valid", 128'(rif.nr_valid_out), 128'(p_acc && rif.data_in.pd_new != 7'd0));
        chk("m_nr_reg", 128'(rif.nr_reg_out), 128'(p_acc ? rif.data_in.pd_new : 7'd0));
        chk("m_rob_we", 128'(rob_we_out), 128'(g >= 0));
        chk("m_rs_we", 128'(rs_we_out), 128'((g >= 0) ? (3'b001 << g) : 3'b000));
        chk("m_pd_new", 128'(rob_pd_new_out), 128'(sh.pd_new));
        chk("m_pd_old", 128'(rob_pd_old_out), 128'(sh.pd_old));
        chk("m_pc", 128'(rob_pc_out), 128'(sh.pc));
        chk("m_query_ps1", 128'(query_ps1), 128'(sh.ps1));
        chk("m_query_ps2", 128'(query_ps2), 128'(sh.ps2));
        chk("m_rs_pkt", 128'(rs_pkt_out), 128'(pk));
        chk("m_lsq_valid", 128'(lsq_alloc_valid_out), 128'(e_mem));
        chk("m_lsq_tag", 128'(lsq_rob_tag_out), 128'(e_mem ? rob_tag_in : 5'd0));
        p_g     = g;
        p_data  = rif.data_in;
        p_flush = mispredict;
    endtask

    task automatic model_commit();
        if (p_flush) begin
            for (int i = 0; i < NCH; i++) q[i].delete();
        end else begin
            if (p_g >= 0) begin
                void'(q[p_g].pop_front());
                rr = (p_g + 1) % NCH;
            end
            if (p_acc) q[p_ch].push_back(p_data);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_eval();
            @(posedge clk);
            if (reset) model_commit();
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic put(input int ch, input rename_data d);
        rif.valid_in  = 1'b1;
        rif.fu_sel_in = 3'(1 << ch);
        rif.data_in   = d;
    endtask

    initial begin
        reset         = 1'b0;
        rif.valid_in  = 1'b0;
        rif.data_in   = '0;
        rif.fu_sel_in = 3'b001;
        pr1_is_ready  = 1'b0;
        pr2_is_ready  = 1'b0;
        cdb_valid     = '0;
        cdb_preg      = '0;
        rob_full_in   = 1'b0;
        rob_tag_in    = '0;
        rs_space_in   = 3'b111;
        mispredict    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        smp();
        chk("t1_reset_ready", 128'(rif.ready_in), 128'(1'b1));
        chk("t1_reset_rob_we", 128'(rob_we_out), 128'(1'b0));
        chk("t1_reset_rs_we", 128'(rs_we_out), 128'(3'b000));

        // 1: accept then grant one cycle later
        nxt(); put(0, mk(32'h100, 7'h33, 7'd1, 7'd2, 7'd9, 7'd3));
        smp();
        chk("t1_nr_valid", 128'(rif.nr_valid_out), 128'(1'b1));
        chk("t1_no_bypass", 128'(rs_we_out), 128'(3'b000));
        nxt(); rif.valid_in = 1'b0;
        smp();
        chk("t1_rs_we", 128'(rs_we_out), 128'(3'b001));
        chk("t1_pd_new", 128'(rob_pd_new_out), 128'(7'd9));

        // 2: full FIFO stalls, no pop-through
        nxt(); rs_space_in = 3'b000; put(0, mk(32'h200, 7'h33, 7'd4, 7'd5, 7'd10, 7'd1));
        smp(); nxt(); put(0, mk(32'h204, 7'h33, 7'd4, 7'd5, 7'd11, 7'd1));
        smp(); nxt(); put(0, mk(32'h208, 7'h33, 7'd4, 7'd5, 7'd12, 7'd1));
        smp();
        chk("t2_full_ready", 128'(rif.ready_in), 128'(1'b0));
        nxt(); rs_space_in = 3'b001;
        smp();
        chk("t2_popthru_ready", 128'(rif.ready_in), 128'(1'b0));
        chk("t2_g1_pd", 128'(rob_pd_new_out), 128'(7'd10));
        nxt();
        smp();
        chk("t2_ready_after_pop", 128'(rif.ready_in), 128'(1'b1));
        chk("t2_g2_pd", 128'(rob_pd_new_out), 128'(7'd11));
        nxt(); rif.valid_in = 1'b0;
        smp();
        chk("t2_g3_pd", 128'(rob_pd_new_out), 128'(7'd12));

        // reset mid-operation drops buffered op and rewinds rr to 0
        nxt(); rs_space_in = 3'b000; put(1, mk(32'h300, 7'h33, 7'd6, 7'd7, 7'd13, 7'd2));
        smp(); nxt(); rif.valid_in = 1'b0; reset = 1'b0;
        smp();
        chk("rst_mid_pd", 128'(rob_pd_new_out), 128'(7'd0));

        // 3: round-robin order from rr=0
        nxt(); reset = 1'b1; put(0, mk(32'h310, 7'h33, 7'd1, 7'd1, 7'd20, 7'd0));
        smp(); nxt(); put(1, mk(32'h314, 7'h63, 7'd1, 7'd1, 7'd21, 7'd0));
        smp(); nxt(); put(2, mk(32'h318, 7'h03, 7'd1, 7'd1, 7'd22, 7'd0));
        smp(); nxt(); put(0, mk(32'h31C, 7'h33, 7'd1, 7'd1, 7'd23, 7'd0));
        smp(); nxt(); rif.valid_in = 1'b0; rs_space_in = 3'b111;
        smp(); chk("t3_g1", 128'(rs_we_out), 128'(3'b001));
        nxt(); smp(); chk("t3_g2", 128'(rs_we_out), 128'(3'b010));
        nxt(); smp(); chk("t3_g3", 128'(rs_we_out), 128'(3'b100));
        nxt(); smp(); chk("t3_g4", 128'(rs_we_out), 128'(3'b001));
        chk("t3_g4_pd", 128'(rob_pd_new_out), 128'(7'd23));

        // 4: CDB forwarding and ps2==0
        nxt(); rs_space_in = 3'b000; put(1, mk(32'h400, 7'h63, 7'd12, 7'd0, 7'd24, 7'd5));
        smp(); nxt(); rif.valid_in = 1'b0; cdb_valid = 3'b001; cdb_preg = 21'(12) << 7;
        smp();
        chk("t4_idle_rs_we", 128'(rs_we_out), 128'(3'b000));
        chk("t4_idle_query", 128'(query_ps1), 128'(7'd12));
        chk("t4_cdb_invalid", 128'(rs_pkt_out.pr1_ready), 128'(1'b0));
        nxt(); rs_space_in = 3'b010; cdb_valid = 3'b010;
        smp();
        chk("t4_rs_we", 128'(rs_we_out), 128'(3'b010));
        chk("t4_pr1_ready", 128'(rs_pkt_out.pr1_ready), 128'(1'b1));
        chk("t4_pr2_ready", 128'(rs_pkt_out.pr2_ready), 128'(1'b1));

        // 5: LSQ allocation on store, none on ALU
        nxt(); rs_space_in = 3'b000; cdb_valid = '0; cdb_preg = '0;
        put(2, mk(32'h500, 7'h23, 7'd3, 7'd4, 7'd25, 7'd6));
        smp(); nxt(); rif.valid_in = 1'b0; rs_space_in = 3'b100; rob_tag_in = 5'd17;
        smp();
        chk("t5_lsq_valid", 128'(lsq_alloc_valid_out), 128'(1'b1));
        chk("t5_lsq_tag", 128'(lsq_rob_tag_out), 128'(5'd17));
        chk("t5_rob_index", 128'(rs_pkt_out.rob_index), 128'(5'd17));
        nxt(); rs_space_in = 3'b000; put(0, mk(32'h504, 7'h33, 7'd3, 7'd4, 7'd26, 7'd7));
        smp(); nxt(); rif.valid_in = 1'b0; rs_space_in = 3'b001; rob_tag_in = 5'd5;
        smp();
        chk("t5_alu_rob_we", 128'(rob_we_out), 128'(1'b1));
        chk("t5_alu_lsq_valid", 128'(lsq_alloc_valid_out), 128'(1'b0));
        chk("t5_alu_lsq_tag", 128'(lsq_rob_tag_out), 128'(5'd0));

        // 6: mispredict flush keeps rr, then rob_full blocks
        nxt(); rs_space_in = 3'b000; rob_tag_in = '0; put(0, mk(32'h600, 7'h33, 7'd1, 7'd2, 7'd27, 7'd0));
        smp(); nxt(); put(1, mk(32'h604, 7'h63, 7'd1, 7'd2, 7'd28, 7'd0));
        smp(); nxt(); put(2, mk(32'h608, 7'h03, 7'd1, 7'd2, 7'd31, 7'd0));
        mispredict = 1'b1; rs_space_in = 3'b111;
        smp();
        chk("t6_mp_ready", 128'(rif.ready_in), 128'(1'b0));
        chk("t6_mp_nr_valid", 128'(rif.nr_valid_out), 128'(1'b0));
        chk("t6_mp_rob_we", 128'(rob_we_out), 128'(1'b0));
        chk("t6_mp_rs_we", 128'(rs_we_out), 128'(3'b000));
        nxt(); mispredict = 1'b0; rif.valid_in = 1'b0; rs_space_in = 3'b000;
        smp();
        chk("t6_empty_pd", 128'(rob_pd_new_out), 128'(7'd0));
        nxt(); put(0, mk(32'h610, 7'h33, 7'd1, 7'd2, 7'd29, 7'd0));
        smp(); nxt(); put(2, mk(32'h614, 7'h33, 7'd1, 7'd2, 7'd30, 7'd0));
        smp(); nxt(); rif.valid_in = 1'b0; rs_space_in = 3'b111; rob_full_in = 1'b1;
        smp();
        chk("t6_full_rob_we", 128'(rob_we_out), 128'(1'b0));
        chk("t6_full_preview", 128'(rob_pd_new_out), 128'(7'd30));
        nxt(); smp();
        chk("t6_hold_rs_we", 128'(rs_we_out), 128'(3'b000));
        nxt(); rob_full_in = 1'b0;
        smp();
        chk("t6_rr_kept", 128'(rs_we_out), 128'(3'b100));
        nxt(); smp();
        chk("t6_last", 128'(rob_pd_new_out), 128'(7'd29));
        nxt(); smp();
        chk("t6_idle", 128'(rs_we_out), 128'(3'b000));

        nxt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
